// File: rtl/uart_pkg.sv
// Shared constants and state encoding for the oversampled UART receive path.
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_e;

endpackage

// File: rtl/uart_byte_fifo.sv
// Synchronous first-word-fall-through FIFO; a push while full is accepted only alongside a pop.
module uart_byte_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         din_i,
    output logic [WIDTH-1:0]         dout_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);
    assign count_o = count_q;
    // Empty head reads as zero so the data output is clean out of reset.
    assign dout_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_msg_ctrl.sv
// Oversampled UART receiver with selectable width/parity, byte FIFO and last-good-byte register.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | line idle, waiting for a 1->0 edge on the synchronised input
// ST_START  | half-bit wait, then confirm the start bit (high = glitch)
// ST_DATA   | one sample per bit time, LSB first, DATA_BITS samples
// ST_PARITY | sample the parity bit (only when parity is enabled)
// ST_STOP   | mid-stop sample; on a low stop bit, hold here until the line releases
module uart_rx_msg_ctrl
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          uart_rxd,
    output logic [DATA_BITS-1:0]          msg_data,
    output logic                          msg_valid,
    input  logic                          msg_ready,
    output logic [DATA_BITS-1:0]          stored_msg,
    output logic                          frame_err,
    output logic                          parity_err,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int              DIV      = CLK_FREQ / BAUD;
    localparam int              CW       = $clog2(DIV);
    localparam logic [CW-1:0]   CNT_BIT  = CW'(DIV - 1);
    localparam logic [CW-1:0]   CNT_HALF = CW'(DIV / 2 - 1);
    localparam logic [3:0]      LAST_BIT = 4'(DATA_BITS - 1);

    if (DIV < 16) begin : g_div_chk
        $error("uart_rx_msg_ctrl: CLK_FREQ/BAUD must be at least 16");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bits_chk
        $error("uart_rx_msg_ctrl: DATA_BITS must be 5..9");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_chk
        $error("uart_rx_msg_ctrl: FIFO_DEPTH must be a power of two >= 2");
    end

    rx_state_e              state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [3:0]             bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   par_bit_q, par_bit_d;
    logic                   brk_q, brk_d;
    logic                   push_q, push_d;
    logic                   frame_err_q, frame_err_d;
    logic                   parity_err_q, parity_err_d;
    logic                   overflow_q;
    logic [DATA_BITS-1:0]   stored_q;
    logic                   rx_meta_q, rxs_q, rxs_prev_q;
    logic                   tick;
    logic                   par_ok;
    logic                   pop;
    logic                   fifo_full;
    logic                   fifo_empty;

    assign tick = (cnt_q == '0);

    always_comb begin
        par_ok = 1'b1;
        if (PARITY == PARITY_ODD) begin
            par_ok = (^shift_q) ^ par_bit_q;
        end else if (PARITY == PARITY_EVEN) begin
            par_ok = ~((^shift_q) ^ par_bit_q);
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q - 1'b1;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        par_bit_d    = par_bit_q;
        brk_d        = brk_q;
        push_d       = 1'b0;
        frame_err_d  = 1'b0;
        parity_err_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (rxs_prev_q && !rxs_q) begin
                    state_d = ST_START;
                    cnt_d   = CNT_HALF;
                end
            end
            ST_START: begin
                if (tick) begin
                    if (rxs_q) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d   = ST_DATA;
                        cnt_d     = CNT_BIT;
                        bit_idx_d = '0;
                    end
                end
            end
            ST_DATA: begin
                if (tick) begin
                    shift_d   = {rxs_q, shift_q[DATA_BITS-1:1]};
                    cnt_d     = CNT_BIT;
                    bit_idx_d = bit_idx_q + 1'b1;
                    if (bit_idx_q == LAST_BIT) begin
                        state_d = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
                    end
                end
            end
            ST_PARITY: begin
                if (tick) begin
                    par_bit_d = rxs_q;
                    cnt_d     = CNT_BIT;
                    state_d   = ST_STOP;
                end
            end
            ST_STOP: begin
                if (brk_q) begin
                    if (rxs_q) begin
                        brk_d   = 1'b0;
                        state_d = ST_IDLE;
                    end
                end else if (tick) begin
                    // A low stop bit outranks any parity result and discards the byte.
                    if (!rxs_q) begin
                        frame_err_d = 1'b1;
                        brk_d       = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        if (par_ok) begin
                            push_d = 1'b1;
                        end else begin
                            parity_err_d = 1'b1;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            par_bit_q    <= 1'b0;
            brk_q        <= 1'b0;
            push_q       <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            par_bit_q    <= par_bit_d;
            brk_q        <= brk_d;
            push_q       <= push_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
        end
    end

    assign pop = msg_valid & msg_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q  <= 1'b1;
            rxs_q      <= 1'b1;
            rxs_prev_q <= 1'b1;
            overflow_q <= 1'b0;
            stored_q   <= '0;
        end else begin
            rx_meta_q  <= uart_rxd;
            rxs_q      <= rx_meta_q;
            rxs_prev_q <= rxs_q;
            overflow_q <= push_q & fifo_full & ~pop;
            // shift_q still holds the byte here: the next frame cannot reach ST_DATA yet.
            if (push_q && (!fifo_full || pop)) begin
                stored_q <= shift_q;
            end
        end
    end

    uart_byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_BITS)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push_q),
        .pop_i   (pop),
        .din_i   (shift_q),
        .dout_o  (msg_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign msg_valid  = ~fifo_empty;
    assign stored_msg = stored_q;
    assign frame_err  = frame_err_q;
    assign parity_err = parity_err_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_uart_rx_msg_ctrl.sv
// Scoreboard bench: two receivers (8N1 and 8E1) driven with directed and random frames.
module tb_uart_rx_msg_ctrl;
    localparam int DIV   = 16;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       rxd_a, rxd_b, ready_a, ready_b;
    logic [7:0] data_a, data_b, stored_a, stored_b;
    logic       valid_a, valid_b, fe_a, fe_b, pe_a, pe_b, ov_a, ov_b;
    logic [2:0] cnt_a, cnt_b;
    bit         rand_ready_b = 1'b0;

    uart_rx_msg_ctrl #(.CLK_FREQ(1_600_000), .BAUD(100_000), .DATA_BITS(8),
                       .PARITY(0), .FIFO_DEPTH(DEPTH)) dut_a (
        .clk(clk), .rst(rst), .uart_rxd(rxd_a), .msg_data(data_a), .msg_valid(valid_a),
        .msg_ready(ready_a), .stored_msg(stored_a), .frame_err(fe_a), .parity_err(pe_a),
        .overflow(ov_a), .fifo_count(cnt_a));

    uart_rx_msg_ctrl #(.CLK_FREQ(1_600_000), .BAUD(100_000), .DATA_BITS(8),
                       .PARITY(2), .FIFO_DEPTH(DEPTH)) dut_b (
        .clk(clk), .rst(rst), .uart_rxd(rxd_b), .msg_data(data_b), .msg_valid(valid_b),
        .msg_ready(ready_b), .stored_msg(stored_b), .frame_err(fe_b), .parity_err(pe_b),
        .overflow(ov_b), .fifo_count(cnt_b));

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] exp_a[$];
    logic [7:0] exp_b[$];
    int         exp_fe[2], exp_pe[2], exp_ov[2];
    int         got_fe[2], got_pe[2], got_ov[2];
    logic [7:0] exp_stored[2];
    logic [7:0] ev_a, ev_b;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every accepted FIFO head and counts flag pulses.
    always @(negedge clk) begin
        if (!rst) begin
            if (valid_a && ready_a) begin
                n_checks++;
                if (exp_a.size() == 0) begin
                    n_fail++;
                    $display("FAIL pop_a: got 0x%0h, expected no data", data_a);
                end else begin
                    ev_a = exp_a.pop_front();
                    if (data_a !== ev_a) begin
                        n_fail++;
                        $display("FAIL pop_a: got 0x%0h, expected 0x%0h", data_a, ev_a);
                    end
                end
            end
            if (valid_b && ready_b) begin
                n_checks++;
                if (exp_b.size() == 0) begin
                    n_fail++;
                    $display("FAIL pop_b: got 0x%0h, expected no data", data_b);
                end else begin
                    ev_b = exp_b.pop_front();
                    if (data_b !== ev_b) begin
                        n_fail++;
                        $display("FAIL pop_b: got 0x%0h, expected 0x%0h", data_b, ev_b);
                    end
                end
            end
            if (fe_a) got_fe[0]++;
            if (pe_a) got_pe[0]++;
            if (ov_a) got_ov[0]++;
            if (fe_b) got_fe[1]++;
            if (pe_b) got_pe[1]++;
            if (ov_b) got_ov[1]++;
        end
    end

    always @(posedge clk) begin
        #2;
        ready_b = rand_ready_b ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Reference model: decides the fate of a frame from its bits alone.
    function automatic void model_frame(input int d, input logic [7:0] data,
                                        input logic par, input logic stop);
        int qsize;
        qsize = (d == 0) ? exp_a.size() : exp_b.size();
        if (!stop) begin
            exp_fe[d]++;
        end else if (d == 1 && (($countones(data) + int'(par)) % 2) != 0) begin
            exp_pe[d]++;
        end else if (qsize >= DEPTH) begin
            exp_ov[d]++;
        end else begin
            if (d == 0) exp_a.push_back(data);
            else        exp_b.push_back(data);
            exp_stored[d] = data;
        end
    endfunction

    task automatic drive(input int d, input logic v, input int cycles);
        if (d == 0) rxd_a = v;
        else        rxd_b = v;
        repeat (cycles) @(posedge clk);
    endtask

    task automatic send(input int d, input logic [7:0] data, input logic par,
                        input logic stop, input int gap);
        drive(d, 1'b0, DIV);
        for (int i = 0; i < 8; i++) drive(d, data[i], DIV);
        if (d == 1) drive(d, par, DIV);
        model_frame(d, data, par, stop);
        drive(d, stop, DIV);
        if (!stop) begin
            drive(d, 1'b0, DIV);
            drive(d, 1'b1, DIV);
        end
        if (gap > 0) drive(d, 1'b1, gap * DIV);
    endtask

    function automatic logic even_par(input logic [7:0] data);
        return 1'($countones(data) % 2);
    endfunction

    task automatic settle(input string tag);
        int t;
        t = 0;
        while ((exp_a.size() != 0 || exp_b.size() != 0) && t < 3000) begin
            @(posedge clk);
            t++;
        end
        check({tag, " drain_timeout"}, 32'(t < 3000), 32'd1);
        repeat (2 * DIV) @(posedge clk);
    endtask

    task automatic check_state(input string tag);
        @(negedge clk);
        check({tag, " frame_err_a"},  got_fe[0], exp_fe[0]);
        check({tag, " parity_err_a"}, got_pe[0], exp_pe[0]);
        check({tag, " overflow_a"},   got_ov[0], exp_ov[0]);
        check({tag, " frame_err_b"},  got_fe[1], exp_fe[1]);
        check({tag, " parity_err_b"}, got_pe[1], exp_pe[1]);
        check({tag, " overflow_b"},   got_ov[1], exp_ov[1]);
        check({tag, " stored_a"},     stored_a, exp_stored[0]);
        check({tag, " stored_b"},     stored_b, exp_stored[1]);
        check({tag, " count_a"},      cnt_a, exp_a.size());
        check({tag, " count_b"},      cnt_b, exp_b.size());
    endtask

    task automatic check_zero(input string tag);
        @(negedge clk);
        check({tag, " valid_a"},  valid_a, 0);
        check({tag, " data_a"},   data_a, 0);
        check({tag, " stored_a"}, stored_a, 0);
        check({tag, " count_a"},  cnt_a, 0);
        check({tag, " flags_a"},  {fe_a, pe_a, ov_a}, 0);
        check({tag, " valid_b"},  valid_b, 0);
        check({tag, " stored_b"}, stored_b, 0);
        check({tag, " flags_b"},  {fe_b, pe_b, ov_b}, 0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 2; i++) begin
            exp_fe[i] = 0; exp_pe[i] = 0; exp_ov[i] = 0;
            got_fe[i] = 0; got_pe[i] = 0; got_ov[i] = 0;
            exp_stored[i] = 8'h00;
        end
        rxd_a = 1'b1; rxd_b = 1'b1; ready_a = 1'b1; rst = 1'b1;
        repeat (5) @(posedge clk);
        check_zero("reset");
        rst = 1'b0;
        repeat (4) @(posedge clk);

        // 1: clean 8N1 byte
        send(0, 8'hA5, 1'b0, 1'b1, 2);
        settle("t1");
        check_state("t1");

        // 2: even parity, good byte then a byte with wrong parity
        send(1, 8'h5A, even_par(8'h5A), 1'b1, 1);
        send(1, 8'h03, 1'b1, 1'b1, 2);
        settle("t2");
        check_state("t2");

        // 3: low stop bit with break, then clean byte
        send(0, 8'h55, 1'b0, 1'b0, 1);
        send(0, 8'h12, 1'b0, 1'b1, 2);
        settle("t3");
        check_state("t3");

        // 4: consumer stalled, fifth byte overflows
        ready_a = 1'b0;
        for (int i = 1; i <= 5; i++) send(0, 8'(i), 1'b0, 1'b1, 0);
        repeat (2 * DIV) @(posedge clk);
        check_state("t4_full");
        ready_a = 1'b1;
        settle("t4");
        check_state("t4");

        // 5: short low glitch on idle line, then a clean frame
        drive(0, 1'b0, 5);
        drive(0, 1'b1, 3 * DIV);
        check_state("t5_glitch");
        send(0, 8'hC3, 1'b0, 1'b1, 1);
        settle("t5");
        check_state("t5");

        // 6: reset in the middle of data bit 4 of 0xFF
        drive(0, 1'b0, DIV);
        for (int i = 0; i < 4; i++) drive(0, 1'b1, DIV);
        drive(0, 1'b1, DIV / 2);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        rst = 1'b0;
        exp_stored[0] = 8'h00;
        exp_stored[1] = 8'h00;
        check_zero("t6_rst");
        drive(0, 1'b1, 6 * DIV);
        send(0, 8'h3C, 1'b0, 1'b1, 1);
        settle("t6");
        check_state("t6");

        // Random traffic on both receivers concurrently
        rand_ready_b = 1'b1;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    logic [7:0] d;
                    d = 8'($urandom);
                    send(0, d, 1'b0, ($urandom_range(0, 7) != 0), $urandom_range(0, 2));
                end
            end
            begin
                for (int i = 0; i < 40; i++) begin
                    logic [7:0] d;
                    logic       p;
                    d = 8'($urandom);
                    p = even_par(d) ^ ($urandom_range(0, 4) == 0);
                    send(1, d, p, ($urandom_range(0, 9) != 0), $urandom_range(0, 2));
                end
            end
        join
        rand_ready_b = 1'b0;
        settle("rand");
        check_state("rand");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
